// File: rtl/color_pkg.sv
// Shared types and constant helpers for the RGB channel-width expander.
// The scale helpers give exact round-to-nearest widening via multiply, add and shift.
package color_pkg;

   typedef enum logic [1:0] {
      ZERO_PAD    = 2'd0,
      REPLICATE   = 2'd1,
      ROUND_SCALE = 2'd2,
      GRAY        = 2'd3
   } expand_mode_t;

   localparam int GRAY_KR = 77;
   localparam int GRAY_KG = 150;
   localparam int GRAY_KB = 29;

   // y = floor((x*A + h) / D) with D = 2^iw-1, A = 2^ow-1, h = (D-1)/2.
   // A reciprocal m = ceil(2^s / D) is exact whenever 2^s >= Nmax * D.
   function automatic int scale_shift(input int iw, input int ow);
      longint d;
      longint a;
      longint h;
      longint bound;
      int     s;
      d     = (longint'(1) << iw) - 1;
      a     = (longint'(1) << ow) - 1;
      h     = (d - 1) / 2;
      bound = (d * a + h) * d;
      s     = 0;
      while ((longint'(1) << s) < bound) s++;
      return s;
   endfunction

   function automatic longint scale_recip(input int iw, input int ow);
      longint d;
      d = (longint'(1) << iw) - 1;
      return ((longint'(1) << scale_shift(iw, ow)) + d - 1) / d;
   endfunction

   function automatic longint scale_mult(input int iw, input int ow);
      return ((longint'(1) << ow) - 1) * scale_recip(iw, ow);
   endfunction

   function automatic longint scale_round(input int iw, input int ow);
      longint d;
      d = (longint'(1) << iw) - 1;
      return ((d - 1) / 2) * scale_recip(iw, ow);
   endfunction

   function automatic int bit_width(input longint v);
      int w;
      w = 1;
      while (w < 63 && (v >> w) != 0) w++;
      return w;
   endfunction

endpackage

// File: rtl/color_expand_channel.sv
// One colour channel: multiply stage, rounding-add stage, shift/select stage.
// Stage enables and per-stage modes come from the top-level control pipeline.
module color_expand_channel
   import color_pkg::*;
#(
   parameter int IW = 5,
   parameter int OW = 8
)
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en1,
   input  logic         en2,
   input  logic         en3,
   input  expand_mode_t mode1,
   input  expand_mode_t mode2,
   input  logic [IW-1:0] x,
   output logic [OW-1:0] y
);

   localparam int     S   = scale_shift(IW, OW);
   localparam longint K_L = scale_mult(IW, OW);
   localparam longint R_L = scale_round(IW, OW);
   localparam int     KW  = bit_width(K_L);
   localparam int     PW  = IW + KW + 1;
   localparam logic [PW-1:0] K   = PW'(K_L);
   localparam logic [PW-1:0] RND = PW'(R_L);

   logic [IW-1:0] x_reg;
   logic [PW-1:0] prod_reg;
   logic [PW-1:0] sum_reg;
   logic [OW-1:0] simple_reg;
   logic [OW-1:0] y_reg;
   logic [OW-1:0] zpad;
   logic [OW-1:0] repl;
   logic [OW-1:0] scaled;

   assign zpad   = OW'(x_reg) << (OW - IW);
   assign scaled = OW'(sum_reg >> S);

   // MSB-first repetition of the input pattern, truncated to OW bits
   generate
      for (genvar gi = 0; gi < OW; gi++) begin : g_repl
         assign repl[OW-1-gi] = x_reg[IW-1-(gi % IW)];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg      <= '0;
         prod_reg   <= '0;
         sum_reg    <= '0;
         simple_reg <= '0;
         y_reg      <= '0;
      end else begin
         if (en1) begin
            x_reg    <= x;
            prod_reg <= PW'(x) * K;
         end
         if (en2) begin
            sum_reg    <= prod_reg + RND;
            simple_reg <= (mode1 == REPLICATE) ? repl : zpad;
         end
         if (en3) begin
            y_reg <= (mode2 == ZERO_PAD || mode2 == REPLICATE) ? simple_reg : scaled;
         end
      end
   end

   assign y = y_reg;

endmodule

// File: rtl/color_expand_pipe.sv
// RGB channel-width expander with valid/ready backpressure, one pixel per cycle.
// Define COLOR_EXPAND_GRAY_EN to add the fourth (grayscale) stage and enable mode 3.
module color_expand_pipe
   import color_pkg::*;
#(
   parameter int R_IW   = 5,
   parameter int G_IW   = 6,
   parameter int B_IW   = 5,
   parameter int OW     = 8,
   parameter int USER_W = 1
)
(
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic [1:0]        mode_in,
   input  logic [R_IW-1:0]   red_in,
   input  logic [G_IW-1:0]   green_in,
   input  logic [B_IW-1:0]   blue_in,
   input  logic [USER_W-1:0] user_in,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [OW-1:0]     red_out,
   output logic [OW-1:0]     green_out,
   output logic [OW-1:0]     blue_out,
   output logic [USER_W-1:0] user_out
);

`ifdef COLOR_EXPAND_GRAY_EN
   localparam int PIPE = 4;
`else
   localparam int PIPE = 3;
`endif

   logic [PIPE:1]     vld_reg;
   logic [PIPE:0]     vld_chain;
   logic [PIPE:1]     ok;
   logic [PIPE:1]     en;
   expand_mode_t      mode_reg [1:PIPE-1];
   logic [USER_W-1:0] user_reg [1:PIPE];
   logic [OW-1:0]     red_ch;
   logic [OW-1:0]     green_ch;
   logic [OW-1:0]     blue_ch;

   assign vld_chain = {vld_reg, valid_in};

   // Stage k may be overwritten when any stage from k to the output is empty,
   // or the output is being taken; this collapses bubbles anywhere downstream.
   generate
      for (genvar gi = 1; gi <= PIPE; gi++) begin : g_ctl
         assign ok[gi] = ready_in | ~(&vld_reg[PIPE:gi]);
         assign en[gi] = ok[gi] & vld_chain[gi-1];
      end
   endgenerate

   assign ready_out = ok[1];
   assign valid_out = vld_reg[PIPE];
   assign user_out  = user_reg[PIPE];

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         vld_reg <= '0;
         for (int k = 1; k <= PIPE - 1; k++) mode_reg[k] <= ZERO_PAD;
         for (int k = 1; k <= PIPE; k++) user_reg[k] <= '0;
      end else begin
         for (int k = 1; k <= PIPE; k++) begin
            if (ok[k]) vld_reg[k] <= vld_chain[k-1];
         end
         if (en[1]) begin
            mode_reg[1] <= expand_mode_t'(mode_in);
            user_reg[1] <= user_in;
         end
         for (int k = 2; k <= PIPE - 1; k++) begin
            if (en[k]) mode_reg[k] <= mode_reg[k-1];
         end
         for (int k = 2; k <= PIPE; k++) begin
            if (en[k]) user_reg[k] <= user_reg[k-1];
         end
      end
   end

   color_expand_channel #(.IW(R_IW), .OW(OW)) u_red (
      .clk(clk_in), .rst_n(rst_n_in),
      .en1(en[1]), .en2(en[2]), .en3(en[3]),
      .mode1(mode_reg[1]), .mode2(mode_reg[2]),
      .x(red_in), .y(red_ch)
   );

   color_expand_channel #(.IW(G_IW), .OW(OW)) u_green (
      .clk(clk_in), .rst_n(rst_n_in),
      .en1(en[1]), .en2(en[2]), .en3(en[3]),
      .mode1(mode_reg[1]), .mode2(mode_reg[2]),
      .x(green_in), .y(green_ch)
   );

   color_expand_channel #(.IW(B_IW), .OW(OW)) u_blue (
      .clk(clk_in), .rst_n(rst_n_in),
      .en1(en[1]), .en2(en[2]), .en3(en[3]),
      .mode1(mode_reg[1]), .mode2(mode_reg[2]),
      .x(blue_in), .y(blue_ch)
   );

`ifdef COLOR_EXPAND_GRAY_EN
   // Coefficients sum to 256, so the luma sum never exceeds 256*(2^OW-1)+128.
   logic [OW+7:0] luma;
   logic [OW-1:0] red_reg;
   logic [OW-1:0] green_reg;
   logic [OW-1:0] blue_reg;
   logic [OW-1:0] gray;

   assign luma = (OW+8)'(GRAY_KR) * (OW+8)'(red_ch)
               + (OW+8)'(GRAY_KG) * (OW+8)'(green_ch)
               + (OW+8)'(GRAY_KB) * (OW+8)'(blue_ch)
               + (OW+8)'(128);
   assign gray = OW'(luma >> 8);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         red_reg   <= '0;
         green_reg <= '0;
         blue_reg  <= '0;
      end else if (en[4]) begin
         if (mode_reg[3] == GRAY) begin
            red_reg   <= gray;
            green_reg <= gray;
            blue_reg  <= gray;
         end else begin
            red_reg   <= red_ch;
            green_reg <= green_ch;
            blue_reg  <= blue_ch;
         end
      end
   end

   assign red_out   = red_reg;
   assign green_out = green_reg;
   assign blue_out  = blue_reg;
`else
   assign red_out   = red_ch;
   assign green_out = green_ch;
   assign blue_out  = blue_ch;
`endif

endmodule
